ram_access_ctrl: RTL and testbench

RAM_ACCESS_CTRL -- requirements
Module: ram_access_ctrl

---
 rtl/ram_access_ctrl.sv | 140 ++++++++++++++
 tb/tb_ram_access_ctrl.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_access_ctrl.sv
// ram_access_ctrl
//   Serialises single-beat read/write commands onto a simple synchronous RAM
//   port and returns one response per command. Only one transaction is in
//   flight at a time.
//
// Ports
//   clk, rst                      clock, asynchronous active-high reset
//   cmd_valid/cmd_ready           command handshake (ready only in IDLE)
//   cmd_write, cmd_addr, cmd_wdata command fields, captured at acceptance
//   rsp_valid/rsp_ready           response handshake (valid only in RESP)
//   rsp_write, rsp_rdata          response kind and read data (0 for writes)
//   we, wr_addr, wr_din           RAM write port
//   re, rd_addr, rd_dout          RAM read port (data one cycle after re)
//   wr_count, rd_count            completed write / read response counters
module ram_access_ctrl #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_write,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  we,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0] wr_din,
    output logic                  re,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] rd_dout,
    output logic [15:0]           wr_count,
    output logic [15:0]           rd_count
);

    typedef enum logic [2:0] {
        IDLE,
        WR,
        RD,
        RD_WAIT,
        RESP
    } state_t;

    state_t state_q, state_d;

    // Held low through reset and set by the first edge afterwards, so
    // cmd_ready cannot rise until one clock after reset is released.
    logic started_q;

    logic accept;
    logic rsp_hs;

    assign accept = cmd_valid & cmd_ready;
    assign rsp_hs = rsp_valid & rsp_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            started_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            started_q <= 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        cmd_ready = 1'b0;
        we        = 1'b0;
        re        = 1'b0;
        rsp_valid = 1'b0;
        case (state_q)
            IDLE: begin
                cmd_ready = started_q;
                if (cmd_valid && started_q) state_d = cmd_write ? WR : RD;
            end
            WR: begin
                we      = 1'b1;
                state_d = RESP;
            end
            RD: begin
                re      = 1'b1;
                state_d = RD_WAIT;
            end
            RD_WAIT: state_d = RESP;
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Command capture: the RAM port registers double as the command holding
    // registers, which also gives "hold last value" behaviour when idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_addr <= '0;
            wr_din  <= '0;
            rd_addr <= '0;
        end else if (accept) begin
            if (cmd_write) begin
                wr_addr <= cmd_addr;
                wr_din  <= cmd_wdata;
            end else begin
                rd_addr <= cmd_addr;
            end
        end
    end

    // Response payload is loaded on entry to RESP and untouched while there.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_write <= 1'b0;
            rsp_rdata <= '0;
        end else if (state_q == WR) begin
            rsp_write <= 1'b1;
            rsp_rdata <= '0;
        end else if (state_q == RD_WAIT) begin
            rsp_write <= 1'b0;
            rsp_rdata <= rd_dout;
        end
    end

    // Counters advance on the response handshake only; they wrap naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_count <= '0;
            rd_count <= '0;
        end else if (rsp_hs) begin
            if (rsp_write) wr_count <= wr_count + 16'd1;
            else           rd_count <= rd_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_ram_access_ctrl.sv
module tb_ram_access_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [3:0]  cmd_addr = '0;
    logic [7:0]  cmd_wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic        rsp_write;
    logic [7:0]  rsp_rdata;
    logic        we;
    logic [3:0]  wr_addr;
    logic [7:0]  wr_din;
    logic        re;
    logic [3:0]  rd_addr;
    logic [7:0]  rd_dout = '0;
    logic [15:0] wr_count;
    logic [15:0] rd_count;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0]  ram     [16];
    logic [7:0]  exp_mem [16];
    logic [8:0]  sb_q    [$];   // {rsp_write, rsp_rdata}
    logic [15:0] exp_wr = '0;
    logic [15:0] exp_rd = '0;

    always #5 clk = ~clk;

    ram_access_ctrl #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
        .rsp_rdata(rsp_rdata),
        .we(we), .wr_addr(wr_addr), .wr_din(wr_din),
        .re(re), .rd_addr(rd_addr), .rd_dout(rd_dout),
        .wr_count(wr_count), .rd_count(rd_count)
    );

    // Synchronous RAM environment
    always @(posedge clk) begin
        if (we) ram[wr_addr] <= wr_din;
        if (re) rd_dout <= ram[rd_addr];
    end

    // One full transaction with cycle-by-cycle strobe checks; hold = cycles of
    // rsp_ready=0 while in RESP.
    task automatic run_txn(input bit w, input logic [3:0] a, input logic [7:0] d, input int hold);
        int n;
        logic [7:0] held;
        logic [8:0] exp_e;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
        rsp_ready = (hold == 0);
        n = 0;
        while (!cmd_ready && n < 20) begin @(negedge clk); n++; end
        n_cmp++;
        if (cmd_ready !== 1'b1) begin
            n_err++; $display("FAIL accept_timeout: cmd_ready=%b required 1", cmd_ready);
            cmd_valid = 1'b0; return;
        end
        sb_q.push_back({w, w ? 8'h00 : exp_mem[a]});
        if (w) exp_mem[a] = d;
        @(negedge clk);
        // scramble command inputs: the captured copy must be used
        cmd_valid = 1'b0; cmd_write = ~w; cmd_addr = ~a; cmd_wdata = ~d;
        n_cmp++;
        if (w) begin
            if ({we, re, rsp_valid, cmd_ready, wr_addr, wr_din} !== {4'b1000, a, d}) begin
                n_err++; $display("FAIL wr_strobe: got we/re/vld/rdy=%b%b%b%b addr=%h din=%h required 1000 %h %h",
                                  we, re, rsp_valid, cmd_ready, wr_addr, wr_din, a, d);
            end
        end else begin
            if ({we, re, rsp_valid, cmd_ready, rd_addr} !== {4'b0100, a}) begin
                n_err++; $display("FAIL rd_strobe: got we/re/vld/rdy=%b%b%b%b addr=%h required 0100 %h",
                                  we, re, rsp_valid, cmd_ready, rd_addr, a);
            end
            @(negedge clk);
            n_cmp++;
            if ({we, re, rsp_valid, cmd_ready} !== 4'b0000) begin
                n_err++; $display("FAIL rd_wait: got we/re/vld/rdy=%b%b%b%b required 0000", we, re, rsp_valid, cmd_ready);
            end
        end
        @(negedge clk);
        n_cmp++;
        if (rsp_valid !== 1'b1) begin
            n_err++; $display("FAIL rsp_latency: rsp_valid=%b required 1 (%s)", rsp_valid, w ? "write" : "read");
        end
        held = rsp_rdata;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({rsp_valid, cmd_ready, we, re, rsp_rdata} !== {4'b1000, held}) begin
                n_err++; $display("FAIL backpressure: got vld/rdy/we/re=%b%b%b%b data=%h required 1000 %h",
                                  rsp_valid, cmd_ready, we, re, rsp_rdata, held);
            end
        end
        rsp_ready = 1'b1;
        n_cmp++;
        if (sb_q.size() == 0) begin
            n_err++; $display("FAIL sb_empty: response with no expected entry");
        end else begin
            exp_e = sb_q.pop_front();
            if ({rsp_write, rsp_rdata} !== exp_e) begin
                n_err++; $display("FAIL rsp_data: got %h required %h", {rsp_write, rsp_rdata}, exp_e);
            end
        end
        if (w) exp_wr = exp_wr + 16'd1; else exp_rd = exp_rd + 16'd1;
        @(negedge clk);
        rsp_ready = 1'b0;
        n_cmp++;
        if ({rsp_valid, cmd_ready, wr_count, rd_count} !== {2'b01, exp_wr, exp_rd}) begin
            n_err++; $display("FAIL post_rsp: got vld/rdy=%b%b wr=%h rd=%h required 01 %h %h",
                              rsp_valid, cmd_ready, wr_count, rd_count, exp_wr, exp_rd);
        end
    endtask

    // Back-to-back stream of cnt commands of one kind, cmd_valid and rsp_ready
    // held high; address = index mod 16, data = address ^ 0xFF.
    task automatic stream(input bit w, input int cnt, input bit chk_gap);
        int acc = 0, rsp = 0, cyc = 0, last = -1, guard = 0;
        logic [3:0] a;
        logic [8:0] exp_e;
        @(negedge clk);
        rsp_ready = 1'b1;
        cmd_write = w;
        while (rsp < cnt && guard < cnt * 5 + 20) begin
            if (rsp_valid) begin
                n_cmp++;
                if (sb_q.size() == 0) begin
                    n_err++; $display("FAIL stream_sb_empty");
                end else begin
                    exp_e = sb_q.pop_front();
                    if ({rsp_write, rsp_rdata} !== exp_e) begin
                        n_err++; $display("FAIL stream_rsp: got %h required %h", {rsp_write, rsp_rdata}, exp_e);
                    end
                end
                if (w) exp_wr = exp_wr + 16'd1; else exp_rd = exp_rd + 16'd1;
                rsp++;
            end
            a = acc[3:0];
            cmd_valid = (acc < cnt);
            cmd_addr  = a;
            cmd_wdata = {4'h0, a} ^ 8'hFF;
            if (cmd_valid && cmd_ready) begin
                if (chk_gap && last >= 0) begin
                    n_cmp++;
                    if (cyc - last != (w ? 3 : 4)) begin
                        n_err++; $display("FAIL throughput: gap %0d cycles required %0d", cyc - last, w ? 3 : 4);
                    end
                end
                last = cyc;
                sb_q.push_back({w, w ? 8'h00 : exp_mem[a]});
                if (w) exp_mem[a] = cmd_wdata;
                acc++;
            end
            @(negedge clk);
            cyc++; guard++;
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b0;
        n_cmp++;
        if (rsp != cnt) begin
            n_err++; $display("FAIL stream_timeout: %0d responses required %0d", rsp, cnt);
        end
        n_cmp++;
        if ({wr_count, rd_count} !== {exp_wr, exp_rd}) begin
            n_err++; $display("FAIL stream_count: got wr=%h rd=%h required %h %h", wr_count, rd_count, exp_wr, exp_rd);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({cmd_ready, rsp_valid, rsp_write, rsp_rdata, we, re, wr_addr, wr_din, rd_addr, wr_count, rd_count} !== '0) begin
            n_err++; $display("FAIL reset_vals: rdy=%b vld=%b we=%b re=%b wc=%h rc=%h required all 0",
                              cmd_ready, rsp_valid, we, re, wr_count, rd_count);
        end
        rst = 1'b0;
        #1;
        n_cmp++;
        if (cmd_ready !== 1'b0) begin
            n_err++; $display("FAIL reset_release_rdy: cmd_ready=%b required 0", cmd_ready);
        end
        @(negedge clk);
        n_cmp++;
        if (cmd_ready !== 1'b1) begin
            n_err++; $display("FAIL reset_first_edge_rdy: cmd_ready=%b required 1", cmd_ready);
        end
    endtask

    task automatic test_write_read;
        run_txn(1'b1, 4'h3, 8'hA5, 0);
        run_txn(1'b0, 4'h3, 8'h00, 0);
    endtask

    task automatic test_fill;
        stream(1'b1, 16, 1'b1);
        stream(1'b0, 16, 1'b1);
    endtask

    task automatic test_backpressure;
        run_txn(1'b1, 4'h0, 8'h3C, 5);
        run_txn(1'b0, 4'h0, 8'h00, 5);
        run_txn(1'b0, 4'hF, 8'h00, 2);
    endtask

    task automatic test_reset_mid_read;
        int n;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 4'h3; rsp_ready = 1'b1;
        n = 0;
        while (!cmd_ready && n < 20) begin @(negedge clk); n++; end
        @(negedge clk);            // RD
        cmd_valid = 1'b0;
        @(negedge clk);            // RD_WAIT
        #1 rst = 1'b1;
        #1;
        n_cmp++;
        if ({cmd_ready, rsp_valid, rsp_write, rsp_rdata, we, re, wr_addr, wr_din, rd_addr, wr_count, rd_count} !== '0) begin
            n_err++; $display("FAIL async_reset: rdy=%b vld=%b data=%h rd_addr=%h wc=%h rc=%h required all 0",
                              cmd_ready, rsp_valid, rsp_rdata, rd_addr, wr_count, rd_count);
        end
        sb_q.delete();
        exp_wr = '0; exp_rd = '0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({rsp_valid, cmd_ready} !== 2'b00) begin
                n_err++; $display("FAIL in_reset: vld/rdy=%b%b required 00", rsp_valid, cmd_ready);
            end
        end
        rst = 1'b0;
        #1;
        n_cmp++;
        if (cmd_ready !== 1'b0) begin
            n_err++; $display("FAIL release_rdy: cmd_ready=%b required 0", cmd_ready);
        end
        @(negedge clk);
        n_cmp++;
        if ({cmd_ready, rsp_valid, rd_count} !== {2'b10, 16'h0000}) begin
            n_err++; $display("FAIL after_release: rdy=%b vld=%b rd_count=%h required 1 0 0000", cmd_ready, rsp_valid, rd_count);
        end
        repeat (3) @(negedge clk);
        rsp_ready = 1'b0;
        n_cmp++;
        if (rsp_valid !== 1'b0) begin
            n_err++; $display("FAIL abandoned_rsp: rsp_valid=%b required 0", rsp_valid);
        end
    endtask

    task automatic test_wrap;
        stream(1'b1, 65535, 1'b0);
        n_cmp++;
        if (wr_count !== 16'hFFFF) begin
            n_err++; $display("FAIL wrap_preload: wr_count=%h required ffff", wr_count);
        end
        run_txn(1'b1, 4'hF, 8'h77, 0);
        n_cmp++;
        if (wr_count !== 16'h0000) begin
            n_err++; $display("FAIL wrap: wr_count=%h required 0000", wr_count);
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            ram[i]     = 8'h00;
            exp_mem[i] = 8'h00;
        end
        test_reset();
        test_write_read();
        test_fill();
        test_backpressure();
        test_reset_mid_read();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
